// File: rtl/fight_pkg.sv
// Shared types and helpers for the combat round controller.
package fight_pkg;

  typedef enum logic [1:0] {
    StReady = 2'b00,
    StFight = 2'b01,
    StKo    = 2'b10
  } round_state_t;

  localparam int unsigned DefMaxHealth = 300;
  localparam int unsigned DefDamage    = 100;

  // Saturating subtract; result never wraps below zero.
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a - b : '0;
  endfunction

endpackage

// File: rtl/player_health_chan.sv
// One player's hit latch, invulnerability counter and saturating health register.
module player_health_chan
  import fight_pkg::*;
#(
  parameter int unsigned HEALTH_W      = 11,
  parameter int unsigned MAX_HEALTH    = DefMaxHealth,
  parameter int unsigned DAMAGE        = DefDamage,
  parameter int unsigned INVULN_FRAMES = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reload,
  input  logic                fight,
  input  logic                frame_start,
  input  logic                hit,
  output logic [HEALTH_W-1:0] health,
  output logic                alive,
  output logic                invuln
);

  localparam int unsigned InvW = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

  logic [HEALTH_W-1:0] health_q;
  logic [InvW-1:0]     inv_q;
  logic                seen_q;
  logic                strike;

  assign alive  = (health_q != '0);
  assign strike = fight & hit & (inv_q == '0) & alive;

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      health_q <= HEALTH_W'(MAX_HEALTH);
      inv_q    <= '0;
      seen_q   <= 1'b0;
    end else begin
      // A strike in the frame_start cycle belongs to the new frame.
      if (strike) begin
        seen_q <= 1'b1;
      end else if (frame_start) begin
        seen_q <= 1'b0;
      end
      if (fight && frame_start) begin
        if (seen_q) begin
          health_q <= HEALTH_W'(sat_sub(32'(health_q), 32'(DAMAGE)));
          inv_q    <= InvW'(INVULN_FRAMES);
        end else if (inv_q != '0) begin
          inv_q <= inv_q - InvW'(1);
        end
      end
    end
  end

  assign health = health_q;
  assign invuln = (inv_q != '0);

endmodule

// File: rtl/combat_round_ctrl.sv
// Round controller: frame edge detect, READY/FIGHT/KO sequencing, KO and winner detection.
module combat_round_ctrl
  import fight_pkg::*;
#(
  parameter int unsigned PLAYERS       = 2,
  parameter int unsigned HEALTH_W      = 11,
  parameter int unsigned MAX_HEALTH    = DefMaxHealth,
  parameter int unsigned DAMAGE        = DefDamage,
  parameter int unsigned INVULN_FRAMES = 30,
  parameter int unsigned READY_FRAMES  = 60,
  parameter int unsigned KO_FRAMES     = 120,
  localparam int unsigned IDX_W        = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         v_sync,
  input  logic [PLAYERS-1:0]           hit,
  input  logic                         restart,
  output logic [PLAYERS*HEALTH_W-1:0]  health,
  output logic [PLAYERS-1:0]           alive,
  output logic [PLAYERS-1:0]           hit_flash,
  output logic [1:0]                   round_state,
  output logic [IDX_W-1:0]             winner,
  output logic                         draw,
  output logic                         frame_start
);

  localparam int unsigned FrameMax = (READY_FRAMES > KO_FRAMES) ? READY_FRAMES : KO_FRAMES;
  localparam int unsigned FcntW    = (FrameMax > 0) ? $clog2(FrameMax + 1) : 1;
  localparam int unsigned PcntW    = $clog2(PLAYERS + 1);

  round_state_t     state_q;
  logic             vs_q;
  logic             fs_q;
  logic [FcntW-1:0] fcnt_q;
  logic [IDX_W-1:0] winner_q;
  logic             draw_q;

  logic [PLAYERS-1:0] invuln;
  logic [PcntW-1:0]   n_alive;
  logic [IDX_W-1:0]   win_idx;
  logic               fight;
  logic               ready_done;
  logic               ko_done;
  logic               reload;

  assign fight      = (state_q == StFight);
  assign ready_done = fs_q && (fcnt_q == FcntW'(READY_FRAMES - 1));
  assign ko_done    = fs_q && (fcnt_q == FcntW'(KO_FRAMES - 1));
  assign reload     = restart | ((state_q == StKo) & ko_done);

  // Descending scan leaves the lowest alive index in win_idx.
  always_comb begin
    n_alive = '0;
    win_idx = '0;
    for (int i = PLAYERS - 1; i >= 0; i--) begin
      n_alive = n_alive + PcntW'(alive[i]);
      if (alive[i]) win_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StReady;
      vs_q     <= 1'b1;
      fs_q     <= 1'b0;
      fcnt_q   <= '0;
      winner_q <= '0;
      draw_q   <= 1'b0;
    end else begin
      vs_q <= v_sync;
      fs_q <= vs_q & ~v_sync;
      if (restart) begin
        state_q  <= StReady;
        fcnt_q   <= '0;
        winner_q <= '0;
        draw_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StReady: begin
            if (ready_done) begin
              state_q <= StFight;
              fcnt_q  <= '0;
            end else if (fs_q) begin
              fcnt_q <= fcnt_q + FcntW'(1);
            end
          end
          StFight: begin
            if (n_alive <= PcntW'(1)) begin
              state_q  <= StKo;
              fcnt_q   <= '0;
              winner_q <= win_idx;
              draw_q   <= (n_alive == '0);
            end
          end
          StKo: begin
            if (ko_done) begin
              state_q  <= StReady;
              fcnt_q   <= '0;
              winner_q <= '0;
              draw_q   <= 1'b0;
            end else if (fs_q) begin
              fcnt_q <= fcnt_q + FcntW'(1);
            end
          end
          default: state_q <= StReady;
        endcase
      end
    end
  end

  for (genvar i = 0; i < PLAYERS; i++) begin : g_chan
    player_health_chan #(
      .HEALTH_W     (HEALTH_W),
      .MAX_HEALTH   (MAX_HEALTH),
      .DAMAGE       (DAMAGE),
      .INVULN_FRAMES(INVULN_FRAMES)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .reload     (reload),
      .fight      (fight),
      .frame_start(fs_q),
      .hit        (hit[i]),
      .health     (health[i*HEALTH_W +: HEALTH_W]),
      .alive      (alive[i]),
      .invuln     (invuln[i])
    );
  end

  assign hit_flash   = invuln & {PLAYERS{state_q != StKo}};
  assign round_state = state_q;
  assign winner      = winner_q;
  assign draw        = draw_q;
  assign frame_start = fs_q;

endmodule

// File: doc/combat_round_ctrl.md
Name: combat_round_ctrl

Overview:
- Parametrised per-player health, hit and round controller for the VGA fighting game; sits between the pixel-level hit detectors (sprite overlap per pixel) and the health-bar/drawbox renderers.
- Converts multi-cycle per-pixel hit levels into at most one damage event per player per frame, with invulnerability frames, KO detection, winner/draw reporting and automatic round restart.
- Supports PLAYERS players, not just two.

Parameters:
- PLAYERS, 2, number of players/channels.
- HEALTH_W, 11, health register width (unsigned).
- MAX_HEALTH, 300, health loaded at round start; must be < 2**HEALTH_W.
- DAMAGE, 100, health removed per accepted hit.
- INVULN_FRAMES, 30, frames a player ignores hits after taking damage; 0 disables.
- READY_FRAMES, 60, frames in READY before FIGHT.
- KO_FRAMES, 120, frames KO is held before the automatic restart.
- IDX_W, $clog2(PLAYERS) min 1, derived localparam, winner index width.

Ports:
- clk  in  1  system clock (pixel-domain clock used by gen_sync).
- rst  in  1  synchronous, active-high reset.
- v_sync  in  1  v_sync from gen_sync; a frame boundary is its falling edge.
- hit  in  PLAYERS  per-pixel level; hit[i]=1 means player i is being struck this pixel.
- restart  in  1  level; sw-driven manual round restart.
- health  out  PLAYERS*HEALTH_W  packed; player i at [i*HEALTH_W +: HEALTH_W].
- alive  out  PLAYERS  health[i] != 0.
- hit_flash  out  PLAYERS  1 while player i's invuln counter is nonzero (renderer tints red).
- round_state  out  2  00 READY, 01 FIGHT, 10 KO.
- winner  out  IDX_W  surviving player index; valid in KO when draw=0.
- draw  out  1  KO entered with zero players alive.
- frame_start  out  1  one-cycle pulse, registered.

Behaviour:
- Reset values:
  - health[i] = MAX_HEALTH; alive = all 1s; hit_flash = 0.
  - round_state = READY; winner = 0; draw = 0; frame_start = 0.
  - Internal frame counter, invuln counters and hit latches = 0; v_sync history register = 1.
- Frame edge:
  - vs_q <= v_sync each cycle.
  - frame_start <= vs_q & ~v_sync.
  - All frame-rate logic acts in the cycle where frame_start = 1.
- Hit latch (FIGHT only):
  - hit_seen[i] <= 1 when hit[i] & (inv_cnt[i] == 0) & alive[i].
  - Cleared at frame_start.
  - A hit in the frame_start cycle itself is latched into the new frame (set wins over clear).
- Frame update, FIGHT, at frame_start, for each i:
  - If hit_seen[i]: health[i] <= (health[i] > DAMAGE) ? health[i] - DAMAGE : 0 (saturating, never wraps); inv_cnt[i] <= INVULN_FRAMES.
  - Else if inv_cnt[i] != 0: inv_cnt[i] decrements.
- Round end:
  - Evaluated one cycle after the health update, from the new alive vector.
  - If popcount(alive) <= 1: state -> KO, frame counter cleared.
  - winner = lowest index with alive = 1; draw = (popcount == 0).
  - Simultaneous KO of all remaining players gives draw = 1, winner = 0.
- FSM:
  - READY: hits ignored; count READY_FRAMES frame_starts, then -> FIGHT.
  - FIGHT: as above.
  - KO: hits ignored; health frozen; hit_flash forced 0; after KO_FRAMES frame_starts -> READY with round reload.
- Round reload: health = MAX_HEALTH, inv_cnt = 0, hit_seen = 0, draw = 0, winner = 0.
- restart:
  - When restart = 1 in any state, the next cycle performs a round reload and enters READY.
  - While restart is held, the block stays in READY with the frame counter held at 0.
  - restart has priority over frame_start events in the same cycle.
- rst mid-round: behaves exactly like the power-on reset values on the next edge, regardless of state.
- Counters: the frame counter is sized for max(READY_FRAMES, KO_FRAMES) and never wraps (held at 0 during reload).

Decomposition:
- Package fight_pkg: round_state_t enum (READY/FIGHT/KO), state encodings, MAX_HEALTH/DAMAGE defaults, sat_sub function.
- One natural sub-module: player_health_chan (hit latch, invuln counter, saturating health), instantiated PLAYERS times in a generate loop.
- The top level holds the edge detector, FSM, popcount and winner encoder.

Test Plan:
- Reset, then 60 frames -> round_state READY for 60 frame_starts, FIGHT after; health = 300/300.
- In FIGHT, hit[1] high for 500 consecutive pixels in one frame -> health[1] = 200 after the frame edge (a single decrement), hit_flash[1] = 1 for 30 frames, hits on player 1 during those frames ignored.
- DAMAGE = 100, player 0 hit in frames 1, 32 and 63 -> health[0] 200, 100, 0; KO the next cycle, winner = 1, draw = 0; after 120 frames health reloads to 300 and state = READY.
- Both players at 100, both hit in the same frame -> both health 0 (saturating, no wrap); KO with draw = 1.
- PLAYERS = 4, players 0, 2 and 3 knocked out in turn -> KO only when the third player reaches 0, winner = 1.
- restart asserted mid-FIGHT coincident with frame_start and hit -> health reloads to MAX_HEALTH, READY, no damage applied; rst asserted in KO -> all outputs at their reset values next cycle.
